bcd_prescaler: RTL and testbench

Parametrised cascaded-BCD clock prescaler: a chain of `DIGITS` decade counters that asserts a single-cycle `tick` every programmed number of enabled cycles. It is the general replacement for the fixed three-digit 1000:1 divider: the digit count is a parameter, the terminal count is a run-time BCD input, and it adds count enable, synchronous restart and an optional one-shot mode. It sits between the system clock and slow timebase consumers (seconds counters, debounce, blink), one instance per timebase.

---
 rtl/bcd_prescaler.sv | 102 ++++++++++
 tb/tb_bcd_prescaler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_prescaler.sv
// Cascaded-BCD prescaler: DIGITS decade counters that pulse tick_o every div_eff+1 enabled cycles.
// Optional one-shot mode (oneshot_i port and done bit) is built when BCD_PRESCALER_ONESHOT_EN is defined.
module bcd_prescaler #(
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   div_i,
`ifdef BCD_PRESCALER_ONESHOT_EN
  input  logic                  oneshot_i,
`endif
  output logic [4*DIGITS-1:0]   count_o,
  output logic [DIGITS-1:0]     c_enable_o,
  output logic                  tick_o
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] div_eff;
  logic [DIGITS-1:0]   c_enable;
  logic                run;
  logic                tick;
  logic                done;

  // Saturating each digit to 9 keeps div_eff a valid BCD value, so the
  // magnitude compare below can treat both operands as plain unsigned vectors.
  always_comb begin
    div_eff = '0;
    for (int i = 0; i < DIGITS; i++) begin
      div_eff[4*i +: 4] = (div_i[4*i +: 4] > 4'd9) ? 4'd9 : div_i[4*i +: 4];
    end
  end

  assign run = resetn_i & en_i & ~load_i & ~done;

  always_comb begin
    c_enable    = '0;
    c_enable[0] = run;
    for (int i = 1; i < DIGITS; i++) begin
      c_enable[i] = c_enable[i-1] & (count_q[4*(i-1) +: 4] == 4'd9);
    end
  end

  // >= rather than == so a mid-run decrease of div_i restarts immediately.
  assign tick = run & (count_q >= div_eff);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i && !done) begin
      if (tick) begin
        count_d = '0;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (c_enable[i]) begin
            count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef BCD_PRESCALER_ONESHOT_EN
  logic done_q, done_d;

  always_comb begin
    done_d = done_q;
    if (load_i) begin
      done_d = 1'b0;
    end else if (tick && oneshot_i) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  assign count_o    = count_q;
  assign c_enable_o = c_enable;
  assign tick_o     = tick;

endmodule

// File: tb/tb_bcd_prescaler.sv
// Bench for bcd_prescaler: 3-digit and 2-digit instances against an integer reference model.
// One-shot scenarios run only when BCD_PRESCALER_ONESHOT_EN is defined.
module tb_bcd_prescaler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, en, load;
  logic [11:0] div3;
  logic [7:0]  div2;
  logic [11:0] count3;
  logic [7:0]  count2;
  logic [2:0]  cen3;
  logic [1:0]  cen2;
  logic        tick3, tick2;
`ifdef BCD_PRESCALER_ONESHOT_EN
  logic        oneshot = 1'b0;
`endif

  bcd_prescaler #(.DIGITS(3)) u_dut3 (
    .clk_i(clk), .resetn_i(resetn), .en_i(en), .load_i(load), .div_i(div3),
`ifdef BCD_PRESCALER_ONESHOT_EN
    .oneshot_i(oneshot),
`endif
    .count_o(count3), .c_enable_o(cen3), .tick_o(tick3)
  );

  bcd_prescaler #(.DIGITS(2)) u_dut2 (
    .clk_i(clk), .resetn_i(resetn), .en_i(en), .load_i(load), .div_i(div2),
`ifdef BCD_PRESCALER_ONESHOT_EN
    .oneshot_i(oneshot),
`endif
    .count_o(count2), .c_enable_o(cen2), .tick_o(tick2)
  );

  typedef struct packed {
    logic [31:0] cnt;
    logic [31:0] cen;
    logic        tk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt_m[2];
  bit   done_m[2];
  int   n3, n2, first3, idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    repeat (n) r = r * 10;
    return r;
  endfunction

  function automatic int nd(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  function automatic int eff(input int v, input int n);
    int r = 0;
    int dd;
    for (int i = 0; i < n; i++) begin
      dd = (v >> (4*i)) & 15;
      if (dd > 9) dd = 9;
      r += dd * p10(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r = r | (32'((v / p10(i)) % 10) << (4*i));
    end
    return r;
  endfunction

  task automatic clr_stats();
    n3 = 0; n2 = 0; first3 = -1; idx = 0;
  endtask

  // Called right after a falling edge with inputs already driven.
  task automatic cyc();
    exp_t e;
    bit   run, osm;
    bit   tk_m[2];
    int   d;
    #1;
    for (int k = 0; k < 2; k++) begin
      d    = eff((k == 0) ? int'(div3) : int'(div2), nd(k));
      run  = resetn && en && !load && !done_m[k];
      e.tk = run && (cnt_m[k] >= d);
      e.cen = '0;
      for (int i = 0; i < nd(k); i++) begin
        e.cen[i] = run && ((cnt_m[k] % p10(i)) == p10(i) - 1);
      end
      e.cnt = to_bcd(cnt_m[k], nd(k));
      tk_m[k] = e.tk;
      exp_q.push_back(e);
    end
    e = exp_q.pop_front();
    check("count3", 32'(count3), e.cnt);
    check("cen3",   32'(cen3),   e.cen);
    check("tick3",  32'(tick3),  32'(e.tk));
    e = exp_q.pop_front();
    check("count2", 32'(count2), e.cnt);
    check("cen2",   32'(cen2),   e.cen);
    check("tick2",  32'(tick2),  32'(e.tk));
    if (tick3) begin
      n3++;
      if (first3 < 0) first3 = idx;
    end
    if (tick2) n2++;
    idx++;
`ifdef BCD_PRESCALER_ONESHOT_EN
    osm = oneshot;
`else
    osm = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      if (!resetn || load) begin
        cnt_m[k] = 0; done_m[k] = 1'b0;
      end else if (en && !done_m[k]) begin
        if (tk_m[k]) begin
          cnt_m[k] = 0; done_m[k] = osm;
        end else begin
          cnt_m[k] = (cnt_m[k] + 1) % p10(nd(k));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    resetn = 1'b0; en = 1'b1; load = 1'b0;
    div3 = 12'h999; div2 = 8'hF5;
    cnt_m[0] = 0; cnt_m[1] = 0; done_m[0] = 1'b0; done_m[1] = 1'b0;
    clr_stats();
    @(negedge clk);
    run_n(3);

    resetn = 1'b1;
    clr_stats();
    run_n(2000);
    check("first_tick_999", first3, 999);
    check("ticks_999", n3, 2);
    check("ticks_f5", n2, 20);

    div3 = 12'h059; load = 1'b1; run_n(1); load = 1'b0;
    clr_stats();
    run_n(200);
    check("ticks_059", n3, 3);
    check("first_tick_059", first3, 59);

    div3 = 12'h000;
    clr_stats();
    run_n(1); en = 1'b0; run_n(1); en = 1'b1; run_n(1);
    check("ticks_000", n3, 2);

    div3 = 12'h999; load = 1'b1; run_n(1); load = 1'b0;
    run_n(500);
    div3 = 12'h100;
    clr_stats();
    run_n(102);
    check("first_tick_dec", first3, 0);
    check("ticks_dec", n3, 2);
    run_n(42);
    check("count_042", 32'(count3), 32'h042);
    load = 1'b1; run_n(1); load = 1'b0;
    run_n(5);

    div3 = 12'h059;
    repeat (300) begin
      en = 1'($urandom_range(0, 1));
      cyc();
    end
    en = 1'b1;

    run_n(7); resetn = 1'b0; run_n(2); resetn = 1'b1; run_n(20);

`ifdef BCD_PRESCALER_ONESHOT_EN
    oneshot = 1'b1; div3 = 12'h009;
    load = 1'b1; run_n(1); load = 1'b0;
    clr_stats();
    run_n(60);
    check("oneshot_ticks", n3, 1);
    check("oneshot_first", first3, 9);
    load = 1'b1; run_n(1); load = 1'b0;
    clr_stats();
    run_n(12);
    check("rearm_ticks", n3, 1);
    check("rearm_first", first3, 9);
    oneshot = 1'b0;
    load = 1'b1; run_n(1); load = 1'b0;
    run_n(25);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
